spectrum_bar_engine: RTL
========================

# spectrum_bar_engine

Parametrised spectrum bar-graph renderer between the band-power calculator and the VGA pixel mixer. It double-buffers NUM_BINS band energies so a frame never tears, and maps each (posx, posy) to a bin, bar and peak-marker pixel through a 2-cycle pipeline. It keeps a per-bin peak-hold with timed decay. It also issues a frame-based update request to the power calculator.

## Interface
- NUM_BINS, 10, number of frequency bins/bars
- VAL_W, 12, bin energy width
- SCREEN_W, 800, active width in pixels; BIN_W = SCREEN_W/NUM_BINS (integer division)
- SCREEN_H, 600, active height in pixels
- GAP_PX, 4, blank columns at the right edge of each bar
- HEIGHT_SHIFT, 3, bar height in pixels = value >> HEIGHT_SHIFT
- HOLD_FRAMES, 30, frames a new peak is held before decay starts
- DECAY_STEP, 16, peak decrement per frame after hold, in value units
- FRAMES_PER_UPDATE, 2, frames between update_req pulses (≥1)

Ports:
- vga_clk  in  1  pixel clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- bins_flat  in  NUM_BINS*VAL_W  bin k at [k*VAL_W +: VAL_W]
- bins_valid  in  1  one-cycle strobe; capture bins_flat into the shadow bank
- frame_start  in  1  one-cycle strobe at start of vertical blanking
- posx  in  10  horizontal pixel position
- posy  in  10  vertical pixel position
- pix_en  in  1  active-video qualifier
- bin_idx  out  8  bin under posx
- bar_val  out  VAL_W  active value of bin_idx
- peak_val  out  VAL_W  peak value of bin_idx
- pixel_on  out  1  pixel lies inside a bar
- pixel_peak  out  1  pixel lies on a peak-marker row
- update_req  out  1  one-cycle request to the power calculator to refresh its values

## Operation
- Reset clears shadow, active and peak banks, hold counters, frame counter and all outputs to 0.
- Shadow bank loads bins_flat on bins_valid.
- Active bank loads the shadow bank on frame_start, all bins in parallel.
- If bins_valid and frame_start coincide, active takes the old shadow contents and shadow takes the new data. The new data appears one frame later.
- Peak update per bin on frame_start, using the value being loaded (v):
  - If v ≥ peak: peak=v and hold=HOLD_FRAMES.
  - Else if hold>0: hold decrements.
  - Else: peak = max(peak−DECAY_STEP, v). Underflow clamps to v, never wraps.
- Frame counter increments on frame_start. When it reaches FRAMES_PER_UPDATE−1, update_req pulses for one cycle and the counter wraps to 0.
- Pipeline stage 1 (registered):
  - k = smallest index with posx < (k+1)*BIN_W.
  - out_of_range = posx ≥ NUM_BINS*BIN_W.
  - gap = (posx − k*BIN_W) ≥ BIN_W−GAP_PX.
  - h = SCREEN_H−1−posy; y_bad = posy ≥ SCREEN_H.
  - pix_en is delayed alongside.
- Pipeline stage 2 (registered):
  - Out of range: bin_idx=0 and bar_val=0. Otherwise bin_idx=k and bar_val=active[k].
  - peak_val = peak[k].
  - pixel_on = en & !out_of_range & !gap & !y_bad & (h < bar_val>>HEIGHT_SHIFT).
  - pixel_peak = same qualifiers & (h == peak_val>>HEIGHT_SHIFT).
  - pixel_on and pixel_peak are independent; both may be 1.
- Arithmetic: comparisons are unsigned, and scaled heights are zero-extended to 10 bits.

## Timing
- Pixel path latency is exactly 2 vga_clk cycles, at full throughput of one pixel per cycle, with no stalls.
- Active and peak banks change only in the cycle after frame_start.
- update_req is asserted in the cycle after the qualifying frame_start.
- Asserting rst_n low mid-frame clears all state immediately. Outputs are 0 until valid inputs have propagated 2 cycles after release.

## Configuration
- SPECTRUM_PEAK_HOLD_EN defined: the peak bank, hold counters and pixel_peak logic are present as described.
- SPECTRUM_PEAK_HOLD_EN undefined: none of that logic is synthesised, and peak_val and pixel_peak are constant 0.

## Test plan
- Reset, then bins_valid with bin3=800, then frame_start. Sweep posx=240..319 at posy=599, pix_en=1. Response 2 cycles later: bin_idx=3, bar_val=800; pixel_on=1 for posx 240..315 and 0 for 316..319 (gap).
- bin3=800 active, posy=499 (h=100). Required: pixel_on=0 and pixel_peak=1, since 800>>3=100.
- Load bin0=1000, then bin0=200 on subsequent frames. Required: peak stays 1000 for 30 frame_starts, then reads 984, 968, … and floors at 200.
- bins_valid and frame_start in the same cycle with new bin0=50, old shadow bin0=700. Required: active bin0=700 this frame and 50 after the next frame_start.
- posx=805 with pix_en=1. Required: bin_idx=0, bar_val=0, pixel_on=0, pixel_peak=0. Repeat with pix_en=0 anywhere on screen: both pixel flags 0.
- 6 frame_starts with FRAMES_PER_UPDATE=2. Required: 3 single-cycle update_req pulses, each one cycle after the 2nd, 4th and 6th frame_start. Repeat with SPECTRUM_PEAK_HOLD_EN undefined: peak_val and pixel_peak stay 0 throughout.

Source files
------------

// File: rtl/spectrum_bar_engine_if.sv
// spectrum_bar_engine_if
// Groups the signals between the spectrum bar engine and its neighbours:
// the band-power calculator and the frame/pixel timing source (master side)
// and the bar renderer (slave side).
//   bins_flat   : NUM_BINS packed band energies, bin k at [k*VAL_W +: VAL_W]
//   bins_valid  : one-cycle strobe, capture bins_flat into the shadow bank
//   frame_start : one-cycle strobe at the start of vertical blanking
//   posx/posy   : current pixel position, pix_en qualifies active video
//   bin_idx, bar_val, peak_val, pixel_on, pixel_peak : pixel results (2-cycle latency)
//   update_req  : one-cycle refresh request back to the power calculator
interface spectrum_bar_engine_if #(
  parameter int NUM_BINS = 10,
  parameter int VAL_W    = 12
);
  logic [NUM_BINS*VAL_W-1:0] bins_flat;
  logic                      bins_valid;
  logic                      frame_start;
  logic [9:0]                posx;
  logic [9:0]                posy;
  logic                      pix_en;
  logic [7:0]                bin_idx;
  logic [VAL_W-1:0]          bar_val;
  logic [VAL_W-1:0]          peak_val;
  logic                      pixel_on;
  logic                      pixel_peak;
  logic                      update_req;

  modport master (
    output bins_flat, bins_valid, frame_start, posx, posy, pix_en,
    input  bin_idx, bar_val, peak_val, pixel_on, pixel_peak, update_req
  );

  modport slave (
    input  bins_flat, bins_valid, frame_start, posx, posy, pix_en,
    output bin_idx, bar_val, peak_val, pixel_on, pixel_peak, update_req
  );
endinterface

// File: rtl/spectrum_bar_engine.sv
// spectrum_bar_engine
// Spectrum bar-graph renderer. Band energies are double-buffered (shadow bank
// written by the power calculator, active bank swapped in at frame_start) so a
// displayed frame never tears. Each pixel position is mapped to a bin, a bar
// pixel and a peak-marker pixel through a 2-stage registered pipeline.
// Ports:
//   vga_clk : pixel clock, the only clock
//   rst_n   : asynchronous active-low reset
//   bus     : spectrum_bar_engine_if.slave (bins in, pixel position in,
//             pixel results and update_req out)
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN
//   defined   -> per-bin peak-hold with timed decay and peak-marker pixels
//   undefined -> no peak logic; peak_val and pixel_peak are constant 0
module spectrum_bar_engine #(
  parameter int NUM_BINS          = 10,
  parameter int VAL_W             = 12,
  parameter int SCREEN_W          = 800,
  parameter int SCREEN_H          = 600,
  parameter int GAP_PX            = 4,
  parameter int HEIGHT_SHIFT      = 3,
  parameter int HOLD_FRAMES       = 30,
  parameter int DECAY_STEP        = 16,
  parameter int FRAMES_PER_UPDATE = 2
) (
  input logic                  vga_clk,
  input logic                  rst_n,
  spectrum_bar_engine_if.slave bus
);

  localparam int BIN_W = SCREEN_W / NUM_BINS;
  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int FC_W  = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

  logic [VAL_W-1:0] shadow_q [NUM_BINS];
  logic [VAL_W-1:0] shadow_d [NUM_BINS];
  logic [VAL_W-1:0] active_q [NUM_BINS];
  logic [VAL_W-1:0] active_d [NUM_BINS];
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             update_req_q, update_req_d;

  logic [IDX_W-1:0] k_q, k_d;
  logic [9:0]       bin_base;
  logic             oor_q, oor_d;
  logic             gap_q, gap_d;
  logic             y_bad_q, y_bad_d;
  logic             en_q, en_d;
  logic [9:0]       h_q, h_d;

  logic             pix_ok;
  logic [9:0]       bar_h;
  logic [7:0]       bin_idx_q, bin_idx_d;
  logic [VAL_W-1:0] bar_val_q, bar_val_d;
  logic             pixel_on_q, pixel_on_d;

  // Shadow captures new energies; active takes the old shadow contents on
  // frame_start, so a coincident bins_valid shows up one frame later.
  always_comb begin
    for (int i = 0; i < NUM_BINS; i++) begin
      shadow_d[i] = bus.bins_valid ? bus.bins_flat[i*VAL_W +: VAL_W] : shadow_q[i];
      active_d[i] = bus.frame_start ? shadow_q[i] : active_q[i];
    end
  end

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    update_req_d = 1'b0;
    if (bus.frame_start) begin
      if (frame_cnt_q == FC_W'(FRAMES_PER_UPDATE - 1)) begin
        frame_cnt_d  = '0;
        update_req_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Bin lookup by descending compare so the smallest matching index wins;
  // avoids a divider. Positions past the last bin fall back to index 0.
  always_comb begin
    k_d      = '0;
    bin_base = '0;
    for (int i = NUM_BINS - 1; i >= 0; i--) begin
      if (bus.posx < 10'((i + 1) * BIN_W)) begin
        k_d      = IDX_W'(i);
        bin_base = 10'(i * BIN_W);
      end
    end
    oor_d   = bus.posx >= 10'(NUM_BINS * BIN_W);
    gap_d   = (bus.posx - bin_base) >= 10'(BIN_W - GAP_PX);
    h_d     = 10'(SCREEN_H - 1) - bus.posy;
    y_bad_d = bus.posy >= 10'(SCREEN_H);
    en_d    = bus.pix_en;
  end

  always_comb begin
    pix_ok     = en_q & ~oor_q & ~gap_q & ~y_bad_q;
    bin_idx_d  = oor_q ? 8'd0 : 8'(k_q);
    bar_val_d  = oor_q ? '0 : active_q[k_q];
    bar_h      = 10'(bar_val_d >> HEIGHT_SHIFT);
    pixel_on_d = pix_ok & (h_q < bar_h);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      frame_cnt_q  <= '0;
      update_req_q <= 1'b0;
      k_q          <= '0;
      oor_q        <= 1'b0;
      gap_q        <= 1'b0;
      y_bad_q      <= 1'b0;
      en_q         <= 1'b0;
      h_q          <= '0;
      bin_idx_q    <= '0;
      bar_val_q    <= '0;
      pixel_on_q   <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      frame_cnt_q  <= frame_cnt_d;
      update_req_q <= update_req_d;
      k_q          <= k_d;
      oor_q        <= oor_d;
      gap_q        <= gap_d;
      y_bad_q      <= y_bad_d;
      en_q         <= en_d;
      h_q          <= h_d;
      bin_idx_q    <= bin_idx_d;
      bar_val_q    <= bar_val_d;
      pixel_on_q   <= pixel_on_d;
    end
  end

  assign bus.bin_idx    = bin_idx_q;
  assign bus.bar_val    = bar_val_q;
  assign bus.pixel_on   = pixel_on_q;
  assign bus.update_req = update_req_q;

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [VAL_W-1:0]  peak_q [NUM_BINS];
  logic [VAL_W-1:0]  peak_d [NUM_BINS];
  logic [HOLD_W-1:0] hold_q [NUM_BINS];
  logic [HOLD_W-1:0] hold_d [NUM_BINS];
  logic [VAL_W-1:0]  peak_val_q, peak_val_d;
  logic              pixel_peak_q, pixel_peak_d;
  logic [9:0]        peak_h;

  // Peak tracks the value entering the active bank. Decay compares the
  // distance to that value first so the subtraction can never wrap.
  always_comb begin
    for (int i = 0; i < NUM_BINS; i++) begin
      peak_d[i] = peak_q[i];
      hold_d[i] = hold_q[i];
      if (bus.frame_start) begin
        if (shadow_q[i] >= peak_q[i]) begin
          peak_d[i] = shadow_q[i];
          hold_d[i] = HOLD_W'(HOLD_FRAMES);
        end else if (hold_q[i] != '0) begin
          hold_d[i] = hold_q[i] - 1'b1;
        end else if ((peak_q[i] - shadow_q[i]) > VAL_W'(DECAY_STEP)) begin
          peak_d[i] = peak_q[i] - VAL_W'(DECAY_STEP);
        end else begin
          peak_d[i] = shadow_q[i];
        end
      end
    end
  end

  always_comb begin
    peak_val_d   = peak_q[k_q];
    peak_h       = 10'(peak_val_d >> HEIGHT_SHIFT);
    pixel_peak_d = pix_ok & (h_q == peak_h);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q       <= '{default: '0};
      hold_q       <= '{default: '0};
      peak_val_q   <= '0;
      pixel_peak_q <= 1'b0;
    end else begin
      peak_q       <= peak_d;
      hold_q       <= hold_d;
      peak_val_q   <= peak_val_d;
      pixel_peak_q <= pixel_peak_d;
    end
  end

  assign bus.peak_val   = peak_val_q;
  assign bus.pixel_peak = pixel_peak_q;
`else
  assign bus.peak_val   = '0;
  assign bus.pixel_peak = 1'b0;
`endif

endmodule
